// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline stage register with a two-entry skid buffer.
// Carries a DATA_W payload and a CTRL_W control vector between two pipeline
// stages using a valid/ready handshake, with freeze (stall), synchronous flush
// and a saturating count of cycles where downstream was ready but the stage
// had nothing to offer.
//
// Storage is a main entry, which drives the outputs, and a skid entry. The skid
// entry catches the beat accepted in the same cycle that downstream first
// stalls. This keeps in_ready a function of registered state (plus
// freeze/flush), so the ready path does not ripple combinationally through
// the pipeline.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // EMPTY: nothing held. FULL: main entry valid. SKID: main and skid both valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   main_data_reg, main_data_next;
  logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
  logic [CNT_W-1:0]    bubble_cnt_reg, bubble_cnt_next;

  logic accept;
  logic drain;
  logic bubble_hit;

  // Handshake outputs. Freeze and flush both block any upstream transfer;
  // freeze also hides the head entry from downstream.
  assign in_ready  = ~flush & ~freeze & (state_reg != ST_SKID);
  assign out_valid = ~freeze & (state_reg != ST_EMPTY);

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // The payload is always visible. The control vector is masked bit by bit
  // so a stage with no valid entry never asserts a write or branch enable
  // downstream.
  assign out_data = main_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi = gi + 1) begin : g_ctrl_mask
      assign out_ctrl[gi] = out_valid & main_ctrl_reg[gi];
    end
  endgenerate

  // A bubble is a cycle where downstream could take a beat but the stage is
  // empty. Frozen and flushed cycles are not counted.
  assign bubble_hit = out_ready & (state_reg == ST_EMPTY) & ~freeze & ~flush;

  assign bubble_cnt = bubble_cnt_reg;

  // Next-state and entry-update logic. Flush overrides everything else;
  // freeze holds all state.
  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;

    if (flush) begin
      // Data registers keep their contents. Only the control vectors are
      // cleared, so killed entries can never re-emerge as live operations.
      state_next     = ST_EMPTY;
      main_ctrl_next = '0;
      skid_ctrl_next = '0;
    end else if (!freeze) begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_FULL;
            main_data_next = in_data;
            main_ctrl_next = in_ctrl;
          end
        end
        ST_FULL: begin
          if (accept && !drain) begin
            // Downstream stalled while a new beat arrived: park it in skid.
            state_next     = ST_SKID;
            skid_data_next = in_data;
            skid_ctrl_next = in_ctrl;
          end else if (accept && drain) begin
            // Pass-through at full rate: the head leaves as the new beat lands.
            state_next     = ST_FULL;
            main_data_next = in_data;
            main_ctrl_next = in_ctrl;
          end else if (drain) begin
            state_next     = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so the only possible event is a drain,
          // which promotes the skid entry to the head.
          if (drain) begin
            state_next     = ST_FULL;
            main_data_next = skid_data_reg;
            main_ctrl_next = skid_ctrl_reg;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating bubble counter; it only returns to zero on reset.
  always_comb begin
    bubble_cnt_next = bubble_cnt_reg;
    if (bubble_hit && (bubble_cnt_reg != CNT_MAX)) begin
      bubble_cnt_next = bubble_cnt_reg + CNT_ONE;
    end
  end

  // State and entry registers. Reset discards both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_reg <= '0;
    end else begin
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg.
// A negedge scoreboard follows every accepted and drained beat. A table of
// per-cycle vectors covers backpressure, freeze and flush. Hand-written
// sequences cover streaming, asynchronous reset and counter saturation.
module tb_pipe_stage_skid_reg;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CW+DW-1:0] sb_q[$];

  typedef struct {
    logic          frz;
    logic          fl;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] idata;
    logic [CW-1:0] ictrl;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_oc;
    logic [NW-1:0] e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vt[NV];

  pipe_stage_skid_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic vec_t mk(input logic frz, input logic fl, input logic iv, input logic ordy,
                              input logic [DW-1:0] idata, input logic [CW-1:0] ictrl,
                              input logic e_ir, input logic e_ov, input logic [DW-1:0] e_od,
                              input logic [CW-1:0] e_oc, input logic [NW-1:0] e_cnt);
    vec_t v;
    v.frz = frz; v.fl = fl; v.iv = iv; v.ordy = ordy; v.idata = idata; v.ictrl = ictrl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Scoreboard: drained beats must match accepted beats in order; flush and reset kill all held beats.
  always @(negedge clk) begin
    logic [CW+DW-1:0] exp_beat;
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_beat", {out_ctrl, out_data}, 64'd0);
        end else begin
          exp_beat = sb_q.pop_front();
          chk("sb_beat", {out_ctrl, out_data}, exp_beat);
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
    end
    if (!out_valid) chk("sb_ctrl_zero_when_idle", out_ctrl, 0);
  end

  // Asserts reset mid-cycle (asynchronously), optionally checks the
  // immediate outputs, and releases it just after the next posedge.
  task automatic do_reset(input bit check_now);
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_bubble_cnt", bubble_cnt, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Backpressure (A,B,C), freeze, then flush while in SKID.
    vt[0]  = mk(0,0,1,0, 32'hA, 8'h11, 1,0, 32'h0, 8'h00, 3'd0);
    vt[1]  = mk(0,0,1,0, 32'hB, 8'h22, 1,1, 32'hA, 8'h11, 3'd0);
    vt[2]  = mk(0,0,1,0, 32'hC, 8'h33, 0,1, 32'hA, 8'h11, 3'd0);
    vt[3]  = mk(0,0,1,0, 32'hC, 8'h33, 0,1, 32'hA, 8'h11, 3'd0);
    vt[4]  = mk(0,0,1,1, 32'hC, 8'h33, 0,1, 32'hA, 8'h11, 3'd0);
    vt[5]  = mk(0,0,1,1, 32'hC, 8'h33, 1,1, 32'hB, 8'h22, 3'd0);
    vt[6]  = mk(0,0,0,1, 32'h0, 8'h00, 1,1, 32'hC, 8'h33, 3'd0);
    vt[7]  = mk(0,0,0,1, 32'h0, 8'h00, 1,0, 32'hC, 8'h00, 3'd0);
    vt[8]  = mk(0,0,1,0, 32'hD, 8'h44, 1,0, 32'hC, 8'h00, 3'd1);
    vt[9]  = mk(1,0,1,1, 32'hE, 8'h55, 0,0, 32'hD, 8'h00, 3'd1);
    vt[10] = mk(1,0,1,1, 32'hE, 8'h55, 0,0, 32'hD, 8'h00, 3'd1);
    vt[11] = mk(1,0,1,1, 32'hE, 8'h55, 0,0, 32'hD, 8'h00, 3'd1);
    vt[12] = mk(0,0,1,1, 32'hE, 8'h55, 1,1, 32'hD, 8'h44, 3'd1);
    vt[13] = mk(0,0,1,0, 32'hF, 8'h66, 1,1, 32'hE, 8'h55, 3'd1);
    vt[14] = mk(0,1,1,0, 32'h99, 8'h77, 0,1, 32'hE, 8'h55, 3'd1);
    vt[15] = mk(0,0,0,1, 32'h0, 8'h00, 1,0, 32'hE, 8'h00, 3'd1);
    vt[16] = mk(1,0,0,1, 32'h0, 8'h00, 0,0, 32'hE, 8'h00, 3'd2);
    vt[17] = mk(0,1,0,1, 32'h0, 8'h00, 0,0, 32'hE, 8'h00, 3'd2);
    vt[18] = mk(0,0,1,1, 32'h12, 8'h81, 1,0, 32'hE, 8'h00, 3'd2);
    vt[19] = mk(0,0,0,1, 32'h0, 8'h00, 1,1, 32'h12, 8'h81, 3'd3);
    vt[20] = mk(0,0,0,0, 32'h0, 8'h00, 1,0, 32'h12, 8'h00, 3'd3);

    in_data = '0; in_ctrl = '0;
    do_reset(0);

    // Back-to-back streaming of 0x10..0x1F with downstream always ready.
    for (int k = 0; k < 18; k++) begin
      in_valid  = (k < 16);
      in_data   = 32'h10 + k;
      in_ctrl   = 8'hA5 ^ 8'(k);
      out_ready = 1'b1;
      @(negedge clk);
      if (k < 16) chk($sformatf("stream%0d_in_ready", k), in_ready, 1);
      chk($sformatf("stream%0d_out_valid", k), out_valid, (k >= 1 && k <= 16));
      if (k >= 1 && k <= 16) chk($sformatf("stream%0d_out_data", k), out_data, 32'h10 + k - 1);
      @(posedge clk);
      #1;
    end

    // Reset arriving in the middle of a stream.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h40 + k; in_ctrl = 8'h0F; out_ready = (k != 2);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    do_reset(1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Bubble counter with CNT_W=3 saturates at 7.
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("cnt%0d", k), bubble_cnt, (k < 7) ? k : 7);
      @(posedge clk);
      #1;
    end

    // Table-driven backpressure / freeze / flush sequence.
    do_reset(0);
    for (int i = 0; i < NV; i++) begin
      freeze = vt[i].frz; flush = vt[i].fl; in_valid = vt[i].iv; out_ready = vt[i].ordy;
      in_data = vt[i].idata; in_ctrl = vt[i].ictrl;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("v%0d_out_data", i), out_data, vt[i].e_od);
      chk($sformatf("v%0d_out_ctrl", i), out_ctrl, vt[i].e_oc);
      chk($sformatf("v%0d_bubble_cnt", i), bubble_cnt, vt[i].e_cnt);
      @(posedge clk);
      #1;
    end
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    @(negedge clk);
    chk("sb_all_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
